// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard, branch-flush and interrupt sequencing controller
// Optional feature macro: HAZ_PERF_EN (adds saturating stall/flush performance counters)
module hazard_ctrl #(
    parameter int STALL_DEPTH = 2,
    parameter int REG_AW      = 4,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ext_stall,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic              i_id_reg_wr,
    input  logic [REG_AW-1:0] i_id_reg_dst,
    input  logic              i_id_branch,
    input  logic              i_id_returni,
    input  logic              i_irq,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_bubble_ex,
    output logic              o_flush_if_id,
    output logic              o_int_take,
    output logic              o_in_isr
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  o_perf_stalls,
    output logic [CNT_W-1:0]  o_perf_flushes
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_VECTOR = 2'd2,
        S_ISR    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_in_isr;
    logic              r_ex_v;
    logic [REG_AW-1:0] r_ex_dst;
    logic              r_mem_v;
    logic [REG_AW-1:0] r_mem_dst;

    logic w_match_rs1;
    logic w_match_rs2;
    logic w_raw;
    logic w_drain;
    logic w_vector;
    logic w_stall;
    logic w_issue;
    logic w_flush;

    // A producer still in EX (or MEM when the MEM slot is tracked) blocks the reader;
    // WB producers are served by the ID write-through bypass. r0 is not exempt.
    assign w_match_rs1 = (r_ex_v && (r_ex_dst == i_id_rs1)) ||
                         ((STALL_DEPTH >= 2) && r_mem_v && (r_mem_dst == i_id_rs1));
    assign w_match_rs2 = (r_ex_v && (r_ex_dst == i_id_rs2)) ||
                         ((STALL_DEPTH >= 2) && r_mem_v && (r_mem_dst == i_id_rs2));

    assign w_raw    = i_id_valid && ((i_id_use_rs1 && w_match_rs1) ||
                                     (i_id_use_rs2 && w_match_rs2));
    assign w_drain  = (r_state == S_DRAIN);
    assign w_vector = (r_state == S_VECTOR);
    assign w_stall  = w_raw || i_ext_stall || w_drain;
    assign w_issue  = i_id_valid && i_id_reg_wr && !w_stall && !w_vector;
    // A stalled branch keeps its slot and flushes once it is allowed to advance.
    assign w_flush  = (i_id_valid && i_id_branch && !w_stall) || w_vector;

    assign o_stall_if    = w_stall;
    assign o_stall_id    = w_stall;
    assign o_bubble_ex   = (w_raw || w_drain) && !i_ext_stall;
    assign o_flush_if_id = w_flush;
    assign o_int_take    = w_vector && !i_ext_stall;
    assign o_in_isr      = r_in_isr;

    // Shift the in-flight destination tracker EX -> MEM; a back-end stall freezes both slots
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ex_v    <= 1'b0;
            r_ex_dst  <= '0;
            r_mem_v   <= 1'b0;
            r_mem_dst <= '0;
        end else if (!i_ext_stall) begin
            r_mem_v   <= r_ex_v;
            r_mem_dst <= r_ex_dst;
            r_ex_v    <= w_issue;
            r_ex_dst  <= w_issue ? i_id_reg_dst : '0;
        end
    end

    // Interrupt entry/exit sequencer: drain in-flight writes, vector once, run handler until returni
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_in_isr <= 1'b0;
        end else if (!i_ext_stall) begin
            case (r_state)
                S_IDLE: begin
                    if (i_irq && !r_in_isr) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_ex_v && !r_mem_v) begin
                        r_state <= S_VECTOR;
                    end
                end
                S_VECTOR: begin
                    r_state  <= S_ISR;
                    r_in_isr <= 1'b1;
                end
                S_ISR: begin
                    if (i_id_valid && i_id_returni && !w_stall) begin
                        r_state  <= S_IDLE;
                        r_in_isr <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_in_isr <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] r_perf_stalls;
    logic [CNT_W-1:0] r_perf_flushes;

    // Saturating counters of front-end stall cycles (hazard or drain) and IF_ID flushes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_stalls  <= '0;
            r_perf_flushes <= '0;
        end else begin
            if ((w_raw || w_drain) && !i_ext_stall && (r_perf_stalls != {CNT_W{1'b1}})) begin
                r_perf_stalls <= r_perf_stalls + CNT_W'(1);
            end
            if (w_flush && (r_perf_flushes != {CNT_W{1'b1}})) begin
                r_perf_flushes <= r_perf_flushes + CNT_W'(1);
            end
        end
    end

    assign o_perf_stalls  = r_perf_stalls;
    assign o_perf_flushes = r_perf_flushes;
`else
    logic [CNT_W-1:0] w_unused_perf;
    assign w_unused_perf = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       es, v, u1, u2, wr, br, ret, irq;
    logic [3:0] rs1, rs2, dst;

    logic stall_if, stall_id, bubble, flush, take, isr;
    logic s1_stall_if, s1_stall_id, s1_bubble, s1_flush, s1_take, s1_isr;
`ifdef HAZ_PERF_EN
    logic [15:0] perf_stalls, perf_flushes, s1_perf_stalls, s1_perf_flushes;
`endif

    hazard_ctrl #(.STALL_DEPTH(2), .REG_AW(4), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ext_stall(es), .i_id_valid(v),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(u1), .i_id_use_rs2(u2),
        .i_id_reg_wr(wr), .i_id_reg_dst(dst), .i_id_branch(br), .i_id_returni(ret),
        .i_irq(irq), .o_stall_if(stall_if), .o_stall_id(stall_id), .o_bubble_ex(bubble),
        .o_flush_if_id(flush), .o_int_take(take), .o_in_isr(isr)
`ifdef HAZ_PERF_EN
        , .o_perf_stalls(perf_stalls), .o_perf_flushes(perf_flushes)
`endif
    );

    hazard_ctrl #(.STALL_DEPTH(1), .REG_AW(4), .CNT_W(16)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_ext_stall(es), .i_id_valid(v),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(u1), .i_id_use_rs2(u2),
        .i_id_reg_wr(wr), .i_id_reg_dst(dst), .i_id_branch(br), .i_id_returni(ret),
        .i_irq(irq), .o_stall_if(s1_stall_if), .o_stall_id(s1_stall_id), .o_bubble_ex(s1_bubble),
        .o_flush_if_id(s1_flush), .o_int_take(s1_take), .o_in_isr(s1_isr)
`ifdef HAZ_PERF_EN
        , .o_perf_stalls(s1_perf_stalls), .o_perf_flushes(s1_perf_flushes)
`endif
    );

    typedef struct {
        logic       es, v;
        logic [3:0] rs1;
        logic       u1;
        logic [3:0] rs2;
        logic       u2, wr;
        logic [3:0] dst;
        logic       br, ret, irq;
        logic [4:0] exp;   // {stall, bubble_ex, flush_if_id, int_take, in_isr}
        logic       c1;    // also check the STALL_DEPTH=1 instance stall
        logic       s1;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int idx    = 0;
    vec_t tbl[$];

    function automatic vec_t V(input logic a_es, input logic a_v, input logic [3:0] a_rs1,
                               input logic a_u1, input logic [3:0] a_rs2, input logic a_u2,
                               input logic a_wr, input logic [3:0] a_dst, input logic a_br,
                               input logic a_ret, input logic a_irq, input logic [4:0] a_exp,
                               input logic a_c1, input logic a_s1);
        vec_t t;
        t.es = a_es; t.v = a_v; t.rs1 = a_rs1; t.u1 = a_u1; t.rs2 = a_rs2; t.u2 = a_u2;
        t.wr = a_wr; t.dst = a_dst; t.br = a_br; t.ret = a_ret; t.irq = a_irq;
        t.exp = a_exp; t.c1 = a_c1; t.s1 = a_s1;
        return t;
    endfunction

    function automatic vec_t IDLE_V(input logic [4:0] a_exp);
        return V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a_exp, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0b expected %0b", nm, idx, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance to just after the next edge
    task automatic apply(input vec_t t);
        es = t.es; v = t.v; rs1 = t.rs1; u1 = t.u1; rs2 = t.rs2; u2 = t.u2;
        wr = t.wr; dst = t.dst; br = t.br; ret = t.ret; irq = t.irq;
        #3;
        chk("stall_if", stall_if, t.exp[4]);
        chk("stall_id", stall_id, t.exp[4]);
        chk("bubble_ex", bubble, t.exp[3]);
        chk("flush_if_id", flush, t.exp[2]);
        chk("int_take", take, t.exp[1]);
        chk("in_isr", isr, t.exp[0]);
        if (t.c1) chk("depth1_stall", s1_stall_id, t.s1);
        @(posedge clk);
        #1;
        idx++;
    endtask

    initial begin
        rst = 1'b1;
        es = 0; v = 0; rs1 = 0; u1 = 0; rs2 = 0; u2 = 0; wr = 0; dst = 0; br = 0; ret = 0; irq = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // RAW stall depth, WB bypass, use/valid gating, branch flush, r0 hazard
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 5'b11000, 1, 1));
        tbl.push_back(V(0, 1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 5'b11000, 1, 0));
        tbl.push_back(V(0, 1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 5'b11000, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 0, 2, 1, 2, 1, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00100, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 5'b11000, 1, 1));
        tbl.push_back(V(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 5'b11000, 1, 0));
        tbl.push_back(V(0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 5'b00100, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 1, 0));
        tbl.push_back(V(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 1, 1));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
        foreach (tbl[i]) apply(tbl[i]);

`ifdef HAZ_PERF_EN
        chk16("perf_stalls_after_table", perf_stalls, 16'd6);
        chk16("perf_flushes_after_table", perf_flushes, 16'd2);
`endif

        // Interrupt with two writes in flight: 2 drain cycles, single vector, handler, return
        apply(V(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5'b00000, 0, 0));
        apply(V(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 5'b00000, 0, 0));
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0));
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 0));
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 0));
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00110, 0, 0));
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00001, 0, 0));
        apply(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00001, 0, 0));
        apply(IDLE_V(5'b00000));
        // Second interrupt; back-end stall during VECTOR defers int_take
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0));
        apply(IDLE_V(5'b11000));
        apply(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0, 0));
        apply(IDLE_V(5'b00110));
        apply(IDLE_V(5'b00001));
        apply(V(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b10001, 0, 0));
        apply(V(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 0, 0));
        apply(IDLE_V(5'b00000));

        // Back-end stall held 3 cycles mid-hazard: slots frozen, no bubbles, 2 stalls after release
        apply(V(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 5'b00000, 0, 0));
        apply(V(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b10000, 0, 0));
        apply(V(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b10000, 0, 0));
        apply(V(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b10000, 0, 0));
        apply(V(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0));
        apply(V(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0));
        apply(V(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0));

        // Reset while draining aborts everything
        apply(V(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5'b00000, 0, 0));
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0));
        apply(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 0));
        rst = 1'b1;
        v = 0; irq = 0; wr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef HAZ_PERF_EN
        chk16("perf_stalls_after_rst", perf_stalls, 16'd0);
        chk16("perf_flushes_after_rst", perf_flushes, 16'd0);
`endif
        apply(V(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0));
        apply(IDLE_V(5'b00000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
